// File: rtl/flex_counter_mc_pkg.sv
// Shared constants for the multi-channel flex counter bank.
package flex_counter_mc_pkg;
  localparam logic DIR_UP       = 1'b0;
  localparam logic DIR_DOWN     = 1'b1;
  localparam int   DEF_CNT_BITS = 8;
  localparam int   DEF_NUM_CH   = 4;
endpackage

// File: rtl/flex_counter_ch.sv
// One counter channel: count, checkpoint and registered rollover flag.
// Priority is clear > revert > step > hold; rollover_val of 0 freezes stepping.
module flex_counter_ch
  import flex_counter_mc_pkg::*;
#(
  parameter int W = DEF_CNT_BITS
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear,
  input  logic         count_enable,
  input  logic         count_down,
  input  logic         save_count,
  input  logic         revert_count,
  input  logic [W-1:0] rollover_val,
  output logic [W-1:0] count_out,
  output logic         rollover_flag
);

  logic [W-1:0] ckpt;
  logic [W-1:0] step_count;
  logic [W-1:0] next_count;
  logic         next_flag;

  always_comb begin
    step_count = count_out;
    next_count = count_out;
    next_flag  = 1'b0;

    // Terminal compares keep the sequence inside 1..R, so no modular wrap occurs.
    if (count_down == DIR_UP)
      step_count = (count_out >= rollover_val) ? W'(1) : count_out + W'(1);
    else
      step_count = ((count_out <= W'(1)) || (count_out > rollover_val)) ?
                   rollover_val : count_out - W'(1);

    if (clear)
      next_count = '0;
    else if (revert_count)
      next_count = ckpt;
    else if (count_enable && (rollover_val != '0))
      next_count = step_count;

    if (rollover_val != '0) begin
      if (count_down == DIR_DOWN)
        next_flag = (next_count == W'(1));
      else
        next_flag = (next_count == rollover_val) && !clear;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
      ckpt          <= '0;
    end else begin
      count_out     <= next_count;
      rollover_flag <= next_flag;
      // Sampling the pre-edge count makes save+revert a swap.
      if (save_count)
        ckpt <= count_out;
    end
  end

endmodule

// File: rtl/flex_counter_mc.sv
// Bank of NUM_CH flex counters with optional atomic snapshot readback.
// Snapshot bank present only when FLEX_COUNTER_MC_SNAPSHOT_EN is defined.
module flex_counter_mc
  import flex_counter_mc_pkg::*;
#(
  parameter int NUM_CNT_BITS = DEF_CNT_BITS,
  parameter int NUM_CH       = DEF_NUM_CH
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic [NUM_CH-1:0]              clear,
  input  logic [NUM_CH-1:0]              count_enable,
  input  logic [NUM_CH-1:0]              count_down,
  input  logic [NUM_CH-1:0]              save_count,
  input  logic [NUM_CH-1:0]              revert_count,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CH*NUM_CNT_BITS-1:0] count_out,
  output logic [NUM_CH-1:0]              rollover_flag,
  input  logic                           snap_req,
  output logic                           snap_valid,
  output logic [NUM_CH*NUM_CNT_BITS-1:0] snap_data
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    flex_counter_ch #(.W(NUM_CNT_BITS)) u_ch (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (clear[i]),
      .count_enable (count_enable[i]),
      .count_down   (count_down[i]),
      .save_count   (save_count[i]),
      .revert_count (revert_count[i]),
      .rollover_val (rollover_val[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
      .count_out    (count_out[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
      .rollover_flag(rollover_flag[i])
    );
  end

`ifdef FLEX_COUNTER_MC_SNAPSHOT_EN
  // All channels are captured from the same pre-edge count_out vector.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      snap_valid <= 1'b0;
      snap_data  <= '0;
    end else begin
      snap_valid <= snap_req;
      if (snap_req)
        snap_data <= count_out;
    end
  end
`else
  logic unused_snap_req;
  assign unused_snap_req = snap_req;
  assign snap_valid      = 1'b0;
  assign snap_data       = '0;
`endif

endmodule

// File: doc/flex_counter_mc.md
# flex_counter_mc

Multi-channel programmable counter bank: NUM_CH independent counters of NUM_CNT_BITS each, with per-channel up/down direction, programmable rollover value, save/revert of a checkpoint count, and a registered rollover flag. An optional atomic snapshot port captures all channels on the same edge for bus readback. It serves timer, baud-generation and protocol bit/byte counting inside peripheral blocks that need several coordinated counters.

## Interface
- NUM_CNT_BITS, 8, width of each channel counter (≥2)
- NUM_CH, 4, number of channels (≥1)
- clk  in  1  clock, all state updates on rising edge
- n_rst  in  1  reset n_rst, asynchronous, active-low; clock clk
- clear  in  NUM_CH  per-channel synchronous clear of count
- count_enable  in  NUM_CH  per-channel advance request
- count_down  in  NUM_CH  per-channel direction, 1 = decrement
- save_count  in  NUM_CH  capture count_out into channel checkpoint
- revert_count  in  NUM_CH  load channel checkpoint into count
- rollover_val  in  NUM_CH*NUM_CNT_BITS  per-channel terminal value, channel i at [i*W +: W]
- count_out  out  NUM_CH*NUM_CNT_BITS  per-channel count, same packing
- rollover_flag  out  NUM_CH  registered; high while count equals terminal value
- snap_req  in  1  request atomic capture of all counts
- snap_valid  out  1  one-cycle pulse, snap_data valid
- snap_data  out  NUM_CH*NUM_CNT_BITS  captured counts

## Operation
- Per channel, next-count priority: clear → 0; else revert_count → checkpoint; else count_enable → step; else hold.
- Up step: if count_out ≥ rollover_val → 1; else count_out+1. Sequence 1..R, wraps to 1.
- Down step: if count_out ≤ 1 or count_out > rollover_val → rollover_val; else count_out−1. Sequence R..1, wraps to R.
- rollover_val = 0: enable has no effect, count holds, flag stays 0. clear/revert still act.
- rollover_flag computed from next count: next_count == rollover_val and rollover_val ≠ 0 and not clear (up mode); next_count == 1 (down mode). Registered with count_out, so flag and count change on the same edge.
- Checkpoint is full NUM_CNT_BITS wide, reset 0, not affected by clear.
- save_count and revert_count together: count loads the old checkpoint; checkpoint captures pre-edge count_out (swap).
- Direction change mid-sequence takes effect on the next enabled step; no reset of count.
- Arithmetic modulo 2^NUM_CNT_BITS never reached: terminal compare prevents overflow for any R.

## Timing
- Reset: count_out = 0, rollover_flag = 0, checkpoints = 0, snap_valid = 0, snap_data = 0.
- Count, flag, checkpoint: 1-cycle latency from inputs to outputs.
- Snapshot: snap_req sampled at edge N captures pre-edge count_out of all channels; snap_valid = 1 during cycle N+1 only; snap_data holds until next capture.
- snap_req held high: capture every cycle, snap_valid high continuously.
- Async reset mid-sequence: everything returns to reset values immediately; no pending snapshot pulse survives.

## Configuration
- FLEX_COUNTER_MC_SNAPSHOT_EN defined: snapshot register bank and snap_valid logic present as above.
- Not defined: snap_req ignored, snap_valid and snap_data tied 0; ports remain for interface stability.

## Structure
- Package flex_counter_mc_pkg: direction localparams (DIR_UP = 0, DIR_DOWN = 1), default width/channel constants.
- Sub-module flex_counter_ch: one channel (count, checkpoint, flag, next-state logic), instantiated NUM_CH times via generate; top holds packing and snapshot bank.

## Test plan
- Reset, W=8, ch0 R=5 up, enable 7 cycles → count 1,2,3,4,5,1,2; flag high exactly with count 5.
- ch1 R=4 down from 0, enable 6 cycles → 4,3,2,1,4,3; flag high with count 1.
- ch2 count 3, save; advance to 5; save+revert same cycle → count 3, checkpoint 5; revert again → 5.
- ch3 R=0 with enable 10 cycles → count 0, flag 0; then clear+revert+enable together → count 0.
- ch0=2, ch1=7 running, snap_req one cycle → next cycle snap_valid=1, snap_data ch0=2, ch1=7 while counts advanced to 3, 6.
- Assert n_rst low mid-count with snap pending → all outputs 0 immediately; build without macro → snap_valid never 1.
